// File: rtl/reg_bank_4.sv
// ============================================================================
// Module   : reg_bank_4
// Purpose  : Four-entry register bank with write-back bypass and a
//            pending-write scoreboard for issue hazard stalls.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bank_4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       rd_sel_a,
    input  logic [1:0]       rd_sel_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    input  logic             issue_valid,
    input  logic [1:0]       issue_dst,
    output logic             issue_ack,
    output logic [3:0]       busy,
    output logic             we_err
);

    logic [WIDTH-1:0] r_regs [4];
    logic [3:0]       r_busy;
    logic             r_we_err;

    logic [3:0]       w_we_minus1;
    logic             w_multi_hot;
    logic             w_one_hot;
    logic [3:0]       w_wr;
    logic [3:0]       w_set;

    // Clearing the lowest set bit leaves something only when two or more were set.
    assign w_we_minus1 = we - 4'd1;
    assign w_multi_hot = |(we & w_we_minus1);
    assign w_one_hot   = (we != 4'd0) && !w_multi_hot;
    assign w_wr        = w_one_hot ? we : 4'd0;

    // A pending destination whose write lands this cycle is not a hazard.
    assign issue_ack = issue_valid && !(r_busy[issue_dst] && !w_wr[issue_dst]);
    assign w_set     = issue_ack ? (4'd1 << issue_dst) : 4'd0;

    assign rd_a   = w_wr[rd_sel_a] ? wdata : r_regs[rd_sel_a];
    assign rd_b   = w_wr[rd_sel_b] ? wdata : r_regs[rd_sel_b];
    assign busy   = r_busy;
    assign we_err = r_we_err;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[i] <= '0;
                    r_busy[i] <= 1'b0;
                end else begin
                    if (w_wr[i]) begin
                        r_regs[i] <= wdata;
                    end
                    // Set beats clear when an issue and its write-back coincide.
                    if (w_set[i]) begin
                        r_busy[i] <= 1'b1;
                    end else if (w_wr[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_err <= 1'b0;
        end else if (w_multi_hot) begin
            r_we_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_4.sv
// ============================================================================
// Module   : tb_reg_bank_4
// Purpose  : Directed vector-table bench for reg_bank_4.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] we;
    logic [7:0] wdata;
    logic [1:0] rd_sel_a;
    logic [1:0] rd_sel_b;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic       issue_valid;
    logic [1:0] issue_dst;
    logic       issue_ack;
    logic [3:0] busy;
    logic       we_err;

    int errors = 0;
    int checks = 0;

    reg_bank_4 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wdata       (wdata),
        .rd_sel_a    (rd_sel_a),
        .rd_sel_b    (rd_sel_b),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_ack   (issue_ack),
        .busy        (busy),
        .we_err      (we_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] we;
        logic [7:0] wdata;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       iv;
        logic [1:0] dst;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_ack;
        logic [3:0] exp_busy;
        logic       exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we          = 4'd0;
        wdata       = 8'd0;
        rd_sel_a    = 2'd0;
        rd_sel_b    = 2'd0;
        issue_valid = 1'b0;
        issue_dst   = 2'd0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 4; r++) begin
            rd_sel_a = 2'(r);
            rd_sel_b = 2'(3 - r);
            #1;
            check({tag, "_rd_a"}, {24'd0, rd_a}, 32'd0);
            check({tag, "_rd_b"}, {24'd0, rd_b}, 32'd0);
        end
        check({tag, "_busy"}, {28'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, we_err}, 32'd0);
    endtask

    initial begin
        //          we       wdata  sa sb iv dst exp_a  exp_b  ack busy     err
        vecs[0]  = '{4'b0100, 8'hA5, 2, 0, 0, 0, 8'hA5, 8'h00, 0, 4'b0000, 0};
        vecs[1]  = '{4'b0000, 8'h00, 2, 3, 0, 0, 8'hA5, 8'h00, 0, 4'b0000, 0};
        vecs[2]  = '{4'b0010, 8'h3C, 1, 1, 0, 0, 8'h3C, 8'h3C, 0, 4'b0000, 0};
        vecs[3]  = '{4'b0000, 8'h00, 0, 1, 1, 3, 8'h00, 8'h3C, 1, 4'b1000, 0};
        vecs[4]  = '{4'b0000, 8'h00, 2, 2, 1, 3, 8'hA5, 8'hA5, 0, 4'b1000, 0};
        vecs[5]  = '{4'b1000, 8'h77, 3, 0, 1, 3, 8'h77, 8'h00, 1, 4'b1000, 0};
        vecs[6]  = '{4'b1000, 8'h11, 3, 3, 0, 0, 8'h11, 8'h11, 0, 4'b0000, 0};
        vecs[7]  = '{4'b0000, 8'h00, 3, 2, 0, 0, 8'h11, 8'hA5, 0, 4'b0000, 0};
        vecs[8]  = '{4'b0001, 8'h01, 0, 1, 0, 0, 8'h01, 8'h3C, 0, 4'b0000, 0};
        vecs[9]  = '{4'b0010, 8'h02, 0, 1, 0, 0, 8'h01, 8'h02, 0, 4'b0000, 0};
        vecs[10] = '{4'b0011, 8'hFF, 0, 1, 1, 0, 8'h01, 8'h02, 1, 4'b0001, 1};
        vecs[11] = '{4'b0000, 8'h00, 0, 1, 1, 2, 8'h01, 8'h02, 1, 4'b0101, 1};
        vecs[12] = '{4'b1000, 8'hC3, 3, 2, 0, 0, 8'hC3, 8'hA5, 0, 4'b0101, 1};
        vecs[13] = '{4'b0000, 8'h00, 3, 0, 1, 2, 8'hC3, 8'h01, 0, 4'b0101, 1};

        idle_inputs();
        rst_n = 1'b0;

        // Write presented across an edge while in reset must be discarded.
        @(negedge clk);
        we    = 4'b0001;
        wdata = 8'hAA;
        @(posedge clk);
        #1;
        we    = 4'd0;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            we          = vecs[i].we;
            wdata       = vecs[i].wdata;
            rd_sel_a    = vecs[i].sa;
            rd_sel_b    = vecs[i].sb;
            issue_valid = vecs[i].iv;
            issue_dst   = vecs[i].dst;
            #2;
            check($sformatf("v%0d_rd_a", i), {24'd0, rd_a}, {24'd0, vecs[i].exp_a});
            check($sformatf("v%0d_rd_b", i), {24'd0, rd_b}, {24'd0, vecs[i].exp_b});
            check($sformatf("v%0d_ack", i), {31'd0, issue_ack}, {31'd0, vecs[i].exp_ack});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", i), {28'd0, busy}, {28'd0, vecs[i].exp_busy});
            check($sformatf("v%0d_err", i), {31'd0, we_err}, {31'd0, vecs[i].exp_err});
        end

        // Asynchronous reset between edges with busy=0101 and we_err set.
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst_n = 1'b1;

        // First edge after release behaves normally.
        @(negedge clk);
        we        = 4'b0100;
        wdata     = 8'h5E;
        issue_valid = 1'b1;
        issue_dst = 2'd1;
        #1;
        check("post_rst_ack", {31'd0, issue_ack}, 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        rd_sel_a = 2'd2;
        rd_sel_b = 2'd0;
        #1;
        check("post_rst_r2", {24'd0, rd_a}, 32'h5E);
        check("post_rst_r0", {24'd0, rd_b}, 32'h00);
        check("post_rst_busy", {28'd0, busy}, 32'b0010);
        check("post_rst_err", {31'd0, we_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

endmodule

`default_nettype wire
